// File: rtl/hamming_code_encoder_if.sv
// Hamming(7,4) encoder bus: input word plus parity select, and the registered codeword.
interface hamming_code_encoder_if;
    logic       in_valid;
    logic [4:1] data_in;
    logic       parity_type;
    logic [7:1] code_out;
    logic       out_valid;

    // Source of data words; sink of codewords
    modport master (
        output in_valid,
        output data_in,
        output parity_type,
        input  code_out,
        input  out_valid
    );

    // Encoder side
    modport slave (
        input  in_valid,
        input  data_in,
        input  parity_type,
        output code_out,
        output out_valid
    );
endinterface

// File: rtl/hamming_code_encoder.sv
// Registered Hamming(7,4) encoder with per-word even/odd parity select.
// Codeword bit index equals Hamming position: parity at 1, 2, 4; data at 3, 5, 6, 7.
module hamming_code_encoder (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming_code_encoder_if.slave   bus
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;

    logic [CODE_W:1] code_q;
    logic [CODE_W:1] code_d;
    logic            valid_q;
    logic            valid_d;

    // Build the codeword; odd parity inverts all three parity bits.
    function automatic logic [CODE_W:1] encode(input logic [DATA_W:1] d, input logic odd);
        logic [CODE_W:1] c;
        c[1] = d[1] ^ d[2] ^ d[4] ^ odd;
        c[2] = d[1] ^ d[3] ^ d[4] ^ odd;
        c[3] = d[1];
        c[4] = d[2] ^ d[3] ^ d[4] ^ odd;
        c[5] = d[2];
        c[6] = d[3];
        c[7] = d[4];
        return c;
    endfunction

    // Next state: load a new codeword only on accepted words, otherwise hold and drop valid.
    always_comb begin
        code_d  = code_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            code_d  = encode(bus.data_in, bus.parity_type);
            valid_d = 1'b1;
        end
    end

    // Output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign bus.code_out  = code_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_hamming_code_encoder.sv
// Directed self-checking bench for hamming_code_encoder.
module tb_hamming_code_encoder;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    hamming_code_encoder_if bus ();

    hamming_code_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and count; one line per mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference codeword: place data, then each parity bit covers positions with that index bit set.
    function automatic logic [7:1] model(input logic [4:1] d, input logic p);
        logic [7:1] c;
        logic       par;
        c    = '0;
        c[3] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = d[4];
        for (int k = 0; k < 3; k++) begin
            par = p;
            for (int pos = 1; pos <= 7; pos++) begin
                if (pos != (1 << k) && ((pos >> k) & 1) == 1)
                    par = par ^ c[pos];
            end
            c[1 << k] = par;
        end
        return c;
    endfunction

    // Single accepted word, then one idle cycle to confirm the valid pulse width.
    task automatic send_one(input string tag, input logic [4:1] d, input logic p, input logic [7:1] exp);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.data_in     = d;
        bus.parity_type = p;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_code"}, 32'(bus.code_out), 32'(exp));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_held"}, 32'(bus.code_out), 32'(exp));
    endtask

    logic [7:1] exp_c;
    logic [4:1] prev_d;
    logic       prev_p;
    logic [7:1] held;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.data_in     = '0;
        bus.parity_type = 1'b0;

        // Reset state
        #12;
        chk("rst_code", 32'(bus.code_out), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_code", 32'(bus.code_out), 32'd0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

        // Hand-computed vectors
        send_one("even_0001", 4'b0001, 1'b0, 7'b0000111);
        send_one("odd_1000",  4'b1000, 1'b1, 7'b1000000);
        send_one("even_0000", 4'b0000, 1'b0, 7'b0000000);
        send_one("odd_0000",  4'b0000, 1'b1, 7'b0001011);
        send_one("even_1111", 4'b1111, 1'b0, 7'b1111111);
        send_one("odd_1111",  4'b1111, 1'b1, 7'b1110100);

        // Back-to-back stream: all data values under both parity types
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.data_in     = 4'd0;
        bus.parity_type = 1'b0;
        for (int i = 0; i < 32; i++) begin
            prev_d = bus.data_in;
            prev_p = bus.parity_type;
            @(negedge clk);
            exp_c = model(prev_d, prev_p);
            chk($sformatf("stream_code_%0d", i), 32'(bus.code_out), 32'(exp_c));
            chk($sformatf("stream_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stream_g1_%0d", i), 32'(^(bus.code_out & 7'b1010101)), 32'(prev_p));
            chk($sformatf("stream_g2_%0d", i), 32'(^(bus.code_out & 7'b1100110)), 32'(prev_p));
            chk($sformatf("stream_g4_%0d", i), 32'(^(bus.code_out & 7'b1111000)), 32'(prev_p));
            if (i < 31) begin
                bus.data_in     = 4'((i + 1) % 16);
                bus.parity_type = ((i + 1) >= 16);
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        // Hold: inputs wiggle while in_valid is low
        held = model(4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.data_in     = 4'(i * 5 + 3);
            bus.parity_type = i[0];
            @(negedge clk);
            chk($sformatf("hold_code_%0d", i), 32'(bus.code_out), 32'(held));
            chk($sformatf("hold_valid_%0d", i), 32'(bus.out_valid), 32'd0);
        end

        // Reset asserted between edges mid-stream
        bus.in_valid    = 1'b1;
        bus.data_in     = 4'b1111;
        bus.parity_type = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_code", 32'(bus.code_out), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("inrst_code", 32'(bus.code_out), 32'd0);
        chk("inrst_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("relrst_code", 32'(bus.code_out), 32'd0);
        chk("relrst_valid", 32'(bus.out_valid), 32'd0);

        // Normal operation resumes after reset
        send_one("after_rst_0110", 4'b0110, 1'b0, 7'b0110011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_code_encoder.md
Name: hamming_code_encoder

Overview:
- Registered Hamming(7,4) encoder.
- Takes a 4-bit data nibble and a parity-type select, and produces a 7-bit codeword with parity bits at positions 1, 2 and 4.
- Sits on the transmit side of an error-protected link, ahead of the channel or storage.
- Even or odd parity is selectable per input word.

Parameters:
- None. Widths are fixed at 4 data bits and 7 code bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  data_in/parity_type are valid this cycle
- data_in  input  4 [4:1]  data bits; data_in[k] = Dk (D4 is the MSB)
- parity_type  input  1  0 = even parity, 1 = odd parity
- code_out  output  7 [7:1]  codeword; bit index = Hamming position
- out_valid  output  1  code_out holds a freshly encoded word

Interface:
- One clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Codeword layout:
  - code_out[1] = P1, code_out[2] = P2, code_out[4] = P4.
  - code_out[3] = D1, code_out[5] = D2, code_out[6] = D3, code_out[7] = D4.
- Even parity (parity_type = 0):
  - P1 = D1^D2^D4
  - P2 = D1^D3^D4
  - P4 = D2^D3^D4
  - Each parity group {1,3,5,7}, {2,3,6,7}, {4,5,6,7} has even weight.
- Odd parity (parity_type = 1):
  - Each of P1, P2, P4 is inverted relative to even parity.
  - Each group has odd weight.
  - Data bit positions are unchanged.
- Timing:
  - Inputs are sampled on the rising clk edge when in_valid = 1.
  - code_out and out_valid update on that same edge: latency is 1 cycle.
  - Throughput is 1 word per cycle; back-to-back in_valid is supported with no bubbles.
  - When in_valid = 0 on an edge, code_out holds its previous value and out_valid goes to 0 on that edge.
  - out_valid is 1 for exactly one cycle per accepted word.
- parity_type is sampled together with data_in; it may change every word.
- No combinational path from inputs to outputs; both outputs are flops.
- Reset:
  - rst_n low clears code_out to 7'b0000000 and out_valid to 0 immediately, with no clock required.
  - Outputs stay cleared while rst_n is low; inputs are ignored.
  - The first edge with rst_n high and in_valid = 1 produces a word with normal 1-cycle latency.
  - Reset asserted mid-stream discards any word in flight; no partial output.
- X/undefined inputs while in_valid = 0 must not disturb the held outputs.

Test Plan:
- Even parity, data_in = 4'b0001 (D1 = 1), in_valid pulse -> next edge: code_out = 7'b0000111, out_valid = 1 for one cycle.
- Odd parity, data_in = 4'b1000 (D4 = 1) -> code_out = 7'b1000000.
- Extremes:
  - data 0000 even -> 0000000; data 0000 odd -> 0001011.
  - data 1111 even -> 1111111; data 1111 odd -> 1110100.
- Exhaustive back-to-back stream of all 16 data values × both parity types, in_valid held high:
  - each code_out matches the formula one cycle after input;
  - group-weight checks pass;
  - out_valid is continuously 1.
- Hold: accept a word, then drop in_valid and toggle data_in/parity_type -> code_out unchanged, out_valid = 0.
- Reset: assert rst_n low between clock edges mid-stream -> code_out = 0 and out_valid = 0 immediately; after release with in_valid low, outputs stay 0.
